// File: rtl/kernel_cache_ctrl.sv
// Kernel cache sequencer for the LKN (burst load) and SHK (window shift) instructions.
// LKN fetches KSIZE consecutive words starting at a captured base address and writes them to
// cache entries 0..KSIZE-1. SHK issues a single shift strobe. The pipeline is stalled while busy.
module kernel_cache_ctrl #(
  parameter int bus   = 32,
  parameter int KSIZE = 9,
  parameter int IW    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sel_cachewr,
  input  logic           sel_cachesh,
  input  logic [bus-1:0] base_addr,
  input  logic           flush,
  input  logic           mem_ack,
  input  logic [bus-1:0] mem_rdata,
  output logic           mem_req,
  output logic [bus-1:0] mem_addr,
  output logic           cache_we,
  output logic [IW-1:0]  cache_waddr,
  output logic [bus-1:0] cache_wdata,
  output logic           cache_shift,
  output logic           stall,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(KSIZE - 1);

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [bus-1:0] base_q, base_d;
  logic           we_q, we_d;
  logic [IW-1:0]  waddr_q, waddr_d;
  logic [bus-1:0] wdata_q, wdata_d;
  logic [bus-1:0] word_off;

  // Byte offset of the current word: idx * 4, zero-extended to the bus width.
  always_comb begin
    word_off             = '0;
    word_off[IW+1:0]     = {idx_q, 2'b00};
  end

  // Next-state logic: request decode in IDLE, word counting in LOAD; flush overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    unique case (state_q)
      IDLE: begin
        // LKN wins over SHK when both are decoded; the dropped SHK is re-issued by decode.
        if (sel_cachewr) begin
          base_d  = base_addr;
          idx_d   = '0;
          state_d = LOAD;
        end else if (sel_cachesh) begin
          state_d = SHIFT;
        end
      end
      LOAD: begin
        // Address and index hold until the memory accepts the request.
        if (mem_ack) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      SHIFT:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Cache write port: one registered pulse per accepted read; a flush blocks any new write.
  always_comb begin
    we_d    = (state_q == LOAD) && mem_ack && !flush;
    waddr_d = we_d ? idx_q     : waddr_q;
    wdata_d = we_d ? mem_rdata : wdata_q;
  end

  // State, counter, base and write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Decoded outputs. stall drops in DONE so the pipeline advances alongside the done pulse.
  assign mem_req     = (state_q == LOAD);
  assign mem_addr    = base_q + word_off;
  assign cache_shift = (state_q == SHIFT);
  assign done        = (state_q == DONE);
  assign stall       = (state_q == LOAD) || (state_q == SHIFT) ||
                       ((state_q == IDLE) && (sel_cachewr || sel_cachesh));
  assign cache_we    = we_q;
  assign cache_waddr = waddr_q;
  assign cache_wdata = wdata_q;

endmodule

// File: tb/tb_kernel_cache_ctrl.sv
// Directed bench for kernel_cache_ctrl: expected cache writes are queued as acks are driven
// and popped by a monitor whenever cache_we is seen.
module tb_kernel_cache_ctrl;

  localparam int KSIZE = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel_cachewr, sel_cachesh, flush, mem_ack;
  logic [31:0] base_addr, mem_rdata;
  logic        mem_req, cache_we, cache_shift, stall, done;
  logic [31:0] mem_addr, cache_wdata;
  logic [3:0]  cache_waddr;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int sh_cnt   = 0;
  logic [35:0] exp_q[$];

  kernel_cache_ctrl #(.bus(32), .KSIZE(KSIZE), .IW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .sel_cachewr(sel_cachewr), .sel_cachesh(sel_cachesh),
    .base_addr(base_addr), .flush(flush),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .cache_we(cache_we), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .cache_shift(cache_shift), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every cache write must match the oldest queued ack.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cache_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_cache_we", 32'd1, 32'd0);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("cache_waddr", {28'd0, cache_waddr}, {28'd0, e[35:32]});
        chk("cache_wdata", cache_wdata, e[31:0]);
      end
    end
    if (rst_n === 1'b1 && cache_shift === 1'b1) sh_cnt++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_shift"}, {31'd0, cache_shift}, 32'd0);
  endtask

  // LKN run. period: ack every period-th LOAD cycle. flush_k: flush once k words are written
  // (flush_k >= KSIZE means no flush). both: raise sel_cachesh together with the request.
  task automatic do_lkn(input logic [31:0] base, input int period, input int flush_k,
                        input logic both);
    int k, w, guard, wstart, sstart;
    logic [31:0] ea;
    wstart = we_cnt;
    sstart = sh_cnt;
    sel_cachewr = 1'b1; sel_cachesh = both; base_addr = base;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("req_stall", {31'd0, stall}, 32'd1);
    chk("req_mem_req", {31'd0, mem_req}, 32'd0);
    next();
    sel_cachewr = 1'b0; sel_cachesh = 1'b0; base_addr = 32'h0;
    k = 0; w = 0; guard = 0;
    while (k < KSIZE && guard < 200) begin
      if (k == flush_k) begin
        flush = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        next();
        flush = 1'b0;
        @(negedge clk);
        chk_quiet("post_flush");
        chk("post_flush_we", {31'd0, cache_we}, 32'd0);
        next();
        @(negedge clk);
        chk("flush_no_done", {31'd0, done}, 32'd0);
        chk("flush_we_total", 32'(we_cnt - wstart), 32'(flush_k));
        return;
      end
      mem_ack   = ((w % period) == (period - 1));
      mem_rdata = 32'hA0 + 32'(k) + (base << 8);
      if (mem_ack) exp_q.push_back({4'(k), mem_rdata});
      @(negedge clk);
      ea = base + 32'(4 * k);
      chk("load_mem_req", {31'd0, mem_req}, 32'd1);
      chk("load_mem_addr", mem_addr, ea);
      chk("load_stall", {31'd0, stall}, 32'd1);
      chk("load_done", {31'd0, done}, 32'd0);
      if (mem_ack) k++;
      w++;
      guard++;
      next();
    end
    if (guard >= 200) chk("load_timeout", 32'(guard), 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("lkn_done", {31'd0, done}, 32'd1);
    chk("lkn_done_stall", {31'd0, stall}, 32'd0);
    chk("lkn_done_mem_req", {31'd0, mem_req}, 32'd0);
    next();
    @(negedge clk);
    chk_quiet("lkn_idle");
    chk("lkn_we_total", 32'(we_cnt - wstart), KSIZE);
    chk("lkn_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("lkn_no_shift", 32'(sh_cnt - sstart), 32'd0);
  endtask

  // SHK run: stall for request + SHIFT, strobe in SHIFT, done the cycle after.
  task automatic do_shk();
    int wstart, sstart;
    wstart = we_cnt;
    sstart = sh_cnt;
    sel_cachesh = 1'b1;
    @(negedge clk);
    chk("shk_req_stall", {31'd0, stall}, 32'd1);
    chk("shk_req_shift", {31'd0, cache_shift}, 32'd0);
    next();
    sel_cachesh = 1'b0;
    @(negedge clk);
    chk("shk_shift", {31'd0, cache_shift}, 32'd1);
    chk("shk_shift_stall", {31'd0, stall}, 32'd1);
    chk("shk_shift_done", {31'd0, done}, 32'd0);
    next();
    @(negedge clk);
    chk("shk_done", {31'd0, done}, 32'd1);
    chk("shk_done_stall", {31'd0, stall}, 32'd0);
    chk("shk_done_shift", {31'd0, cache_shift}, 32'd0);
    next();
    @(negedge clk);
    chk_quiet("shk_idle");
    chk("shk_shift_count", 32'(sh_cnt - sstart), 32'd1);
    chk("shk_no_we", 32'(we_cnt - wstart), 32'd0);
    next();
  endtask

  initial begin
    rst_n = 1'b0;
    sel_cachewr = 1'b0; sel_cachesh = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; base_addr = 32'h0; mem_rdata = 32'h0;
    #2;
    chk_quiet("reset");
    chk("reset_we", {31'd0, cache_we}, 32'd0);
    chk("reset_waddr", {28'd0, cache_waddr}, 32'd0);
    chk("reset_wdata", cache_wdata, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    next();
    rst_n = 1'b1;
    next();

    // T2: back-to-back acks from 0x100
    do_lkn(32'h100, 1, KSIZE, 1'b0);
    next();
    // T3: ack every third cycle
    do_lkn(32'h4000, 3, KSIZE, 1'b0);
    next();
    // T4: lone SHK
    do_shk();
    // T5: simultaneous LKN and SHK; LKN only
    do_lkn(32'h800, 1, KSIZE, 1'b1);
    next();
    // T6: wrapping address, flush after the fourth write
    do_lkn(32'hFFFFFFF8, 1, 4, 1'b0);
    next();

    // flush beats a new request in IDLE
    sel_cachesh = 1'b1; flush = 1'b1;
    next();
    sel_cachesh = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk_quiet("flush_idle_req");
    next();

    // T1: async reset mid-LOAD while a write pulse is on the port
    sel_cachewr = 1'b1; base_addr = 32'h200; mem_ack = 1'b0;
    next();
    sel_cachewr = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5A5A0000;
    exp_q.push_back({4'd0, 32'h5A5A0000});
    next();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("t1_we_before_reset", {31'd0, cache_we}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("t1_async");
    chk("t1_async_we", {31'd0, cache_we}, 32'd0);
    chk("t1_async_waddr", {28'd0, cache_waddr}, 32'd0);
    chk("t1_async_wdata", cache_wdata, 32'd0);
    next();
    next();
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("t1_idle");
    next();
    do_shk();

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
